// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_RADR_W = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic s;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // EX/MEM register contents for an instruction waiting on memory.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] adr;
    logic [DEF_DATA_W-1:0] wdat;
    logic                  rd;
    logic                  wr;
    logic                  reg_write;
    logic [DEF_RADR_W-1:0] wadr;
    flags_t                flags;
  } exmem_t;

  // Registered bundle handed to write-back.
  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] dat;
    logic [DEF_RADR_W-1:0] wadr;
    logic                  reg_write;
    flags_t                flags;
  } wb_t;

  function automatic logic is_mem_op(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_if.sv
// Main-memory request/acknowledge bus between the stage and memory.
interface mem_if #(
  parameter int DATA_W = mem_pkg::DEF_DATA_W
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdat;
  logic [DATA_W-1:0] mem_rdat;
  logic              mem_ack;

  // Pipeline stage side: issues requests, receives completion.
  modport master (
    output mem_req, mem_we, mem_adr, mem_wdat,
    input  mem_rdat, mem_ack
  );

  // Memory side.
  modport slave (
    input  mem_req, mem_we, mem_adr, mem_wdat,
    output mem_rdat, mem_ack
  );
endinterface

// File: rtl/mem_watchdog.sv
// Cycle counter that flags an access which has waited MEM_TIMEOUT cycles.
module mem_watchdog #(
  parameter int CNT_W       = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  // Count waiting cycles; clear has priority so the count never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = (cnt == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register, load/store sequencing over
// a req/ack bus with a watchdog, and a registered write-back bundle.
// Internal struct widths follow the package defaults for DATA_W/RADR_W.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RADR_W      = DEF_RADR_W,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_ex,
  input  logic [DATA_W-1:0] ALUres_ex,
  input  logic [DATA_W-1:0] rd1_ex,
  input  logic              mem_read_ex,
  input  logic              mem_write_ex,
  input  logic              reg_write_ex,
  input  logic [RADR_W-1:0] wadr_ex,
  input  logic              S_ex,
  input  logic              Z_ex,
  input  logic              C_ex,
  input  logic              V_ex,
  input  logic              flush,
  output logic              stall_mem,
  mem_if.master             bus,
  output logic              valid_wb,
  output logic [DATA_W-1:0] wb_dat,
  output logic [RADR_W-1:0] wadr_wb,
  output logic              reg_write_wb,
  output logic              S_wb,
  output logic              Z_wb,
  output logic              C_wb,
  output logic              V_wb,
  output logic              mem_err
);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_ACCESS = ACCESS;

  logic [0:0] state;
  exmem_t     exmem;
  wb_t        wb_q;
  flags_t     flags_ex;
  logic       capture;
  logic       in_access;
  logic       expire;

  assign flags_ex  = '{s: S_ex, z: Z_ex, c: C_ex, v: V_ex};
  assign capture   = valid_ex & ~flush;
  assign in_access = (state == ST_ACCESS);

  mem_watchdog #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (~in_access | bus.mem_ack),
    .enable (in_access),
    .expire (expire)
  );

  // Sequence capture, memory access and write-back result registration.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the EX/MEM register is reset even though it is only read in
  // ACCESS, so the bus outputs are well defined from the first cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      exmem   <= '0;
      wb_q    <= '0;
      mem_err <= 1'b0;
    end else begin
      wb_q.valid <= 1'b0;
      if (!in_access) begin
        if (capture && is_mem_op(mem_read_ex, mem_write_ex)) begin
          exmem <= '{adr: ALUres_ex, wdat: rd1_ex, rd: mem_read_ex,
                     wr: mem_write_ex, reg_write: reg_write_ex,
                     wadr: wadr_ex, flags: flags_ex};
          state <= ST_ACCESS;
        end else if (capture) begin
          wb_q <= '{valid: 1'b1, dat: ALUres_ex, wadr: wadr_ex,
                    reg_write: reg_write_ex, flags: flags_ex};
        end
      end else if (bus.mem_ack) begin
        wb_q <= '{valid: 1'b1, dat: exmem.rd ? bus.mem_rdat : exmem.adr,
                  wadr: exmem.wadr, reg_write: exmem.reg_write,
                  flags: exmem.flags};
        state <= ST_IDLE;
      end else if (expire) begin
        mem_err <= 1'b1;
        state   <= ST_IDLE;
      end
    end
  end

  // Bus outputs are zero outside ACCESS so reset drops them immediately.
  assign stall_mem    = in_access;
  assign bus.mem_req  = in_access;
  assign bus.mem_we   = in_access & exmem.wr;
  assign bus.mem_adr  = in_access ? exmem.adr  : '0;
  assign bus.mem_wdat = in_access ? exmem.wdat : '0;

  assign valid_wb     = wb_q.valid;
  assign wb_dat       = wb_q.dat;
  assign wadr_wb      = wb_q.wadr;
  assign reg_write_wb = wb_q.reg_write;
  assign S_wb         = wb_q.flags.s;
  assign Z_wb         = wb_q.flags.z;
  assign C_wb         = wb_q.flags.c;
  assign V_wb         = wb_q.flags.v;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (watchdog shortened to 4).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_ex;
  logic [15:0] ALUres_ex;
  logic [15:0] rd1_ex;
  logic        mem_read_ex;
  logic        mem_write_ex;
  logic        reg_write_ex;
  logic [2:0]  wadr_ex;
  logic        S_ex, Z_ex, C_ex, V_ex;
  logic        flush;
  logic        stall_mem;
  logic        valid_wb;
  logic [15:0] wb_dat;
  logic [2:0]  wadr_wb;
  logic        reg_write_wb;
  logic        S_wb, Z_wb, C_wb, V_wb;
  logic        mem_err;

  int n_assert = 0;
  int n_fail   = 0;
  int req_cycles;
  logic any_valid;

  mem_if #(.DATA_W(16)) bus ();

  mem_stage #(
    .DATA_W      (16),
    .RADR_W      (3),
    .MEM_TIMEOUT (4),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_ex     (valid_ex),
    .ALUres_ex    (ALUres_ex),
    .rd1_ex       (rd1_ex),
    .mem_read_ex  (mem_read_ex),
    .mem_write_ex (mem_write_ex),
    .reg_write_ex (reg_write_ex),
    .wadr_ex      (wadr_ex),
    .S_ex         (S_ex),
    .Z_ex         (Z_ex),
    .C_ex         (C_ex),
    .V_ex         (V_ex),
    .flush        (flush),
    .stall_mem    (stall_mem),
    .bus          (bus.master),
    .valid_wb     (valid_wb),
    .wb_dat       (wb_dat),
    .wadr_wb      (wadr_wb),
    .reg_write_wb (reg_write_wb),
    .S_wb         (S_wb),
    .Z_wb         (Z_wb),
    .C_wb         (C_wb),
    .V_wb         (V_wb),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    valid_ex = 0; ALUres_ex = '0; rd1_ex = '0; mem_read_ex = 0;
    mem_write_ex = 0; reg_write_ex = 0; wadr_ex = '0; flush = 0;
    {S_ex, Z_ex, C_ex, V_ex} = 4'b0000;
  endtask

  initial begin
    clear_ex();
    bus.mem_ack  = 0;
    bus.mem_rdat = '0;
    reset = 1;
    #1;
    check("reset_valid_wb", valid_wb, 0);
    check("reset_stall", stall_mem, 0);
    check("reset_req", bus.mem_req, 0);
    check("reset_err", mem_err, 0);
    tick();
    reset = 0;

    // ALU ops back to back
    valid_ex = 1; ALUres_ex = 16'h1234; reg_write_ex = 1; wadr_ex = 3;
    S_ex = 1; C_ex = 1;
    #1 check("alu_stall", stall_mem, 0);
    tick();
    check("alu_valid", valid_wb, 1);
    check("alu_dat", wb_dat, 16'h1234);
    check("alu_wadr", wadr_wb, 3);
    check("alu_rw", reg_write_wb, 1);
    check("alu_flags", {S_wb, Z_wb, C_wb, V_wb}, 4'b1010);
    ALUres_ex = 16'h5678; wadr_ex = 5; S_ex = 0; C_ex = 0; Z_ex = 1;
    tick();
    check("alu2_valid", valid_wb, 1);
    check("alu2_dat", wb_dat, 16'h5678);
    check("alu2_wadr", wadr_wb, 5);
    check("alu2_flags", {S_wb, Z_wb, C_wb, V_wb}, 4'b0100);
    check("alu2_stall", stall_mem, 0);
    clear_ex();
    tick();
    check("idle_valid", valid_wb, 0);

    // mem_ack in IDLE is ignored
    bus.mem_ack = 1; bus.mem_rdat = 16'h7777;
    tick();
    check("idle_ack_valid", valid_wb, 0);
    check("idle_ack_stall", stall_mem, 0);
    bus.mem_ack = 0;

    // Load, ack in third ACCESS cycle
    valid_ex = 1; ALUres_ex = 16'h0040; mem_read_ex = 1; reg_write_ex = 1;
    wadr_ex = 2; V_ex = 1;
    tick();
    clear_ex();
    check("ld_valid0", valid_wb, 0);
    check("ld_stall1", stall_mem, 1);
    check("ld_req1", bus.mem_req, 1);
    check("ld_adr1", bus.mem_adr, 16'h0040);
    check("ld_we1", bus.mem_we, 0);
    tick();
    check("ld_req2", bus.mem_req, 1);
    check("ld_adr2", bus.mem_adr, 16'h0040);
    tick();
    check("ld_req3", bus.mem_req, 1);
    check("ld_stall3", stall_mem, 1);
    bus.mem_ack = 1; bus.mem_rdat = 16'hBEEF;
    tick();
    bus.mem_ack = 0; bus.mem_rdat = '0;
    check("ld_valid", valid_wb, 1);
    check("ld_dat", wb_dat, 16'hBEEF);
    check("ld_wadr", wadr_wb, 2);
    check("ld_flags", {S_wb, Z_wb, C_wb, V_wb}, 4'b0001);
    check("ld_stall_end", stall_mem, 0);
    check("ld_req_end", bus.mem_req, 0);
    tick();
    check("ld_pulse", valid_wb, 0);

    // Store; upstream changes while stalled must not be sampled
    valid_ex = 1; ALUres_ex = 16'h0010; rd1_ex = 16'h00AA; mem_write_ex = 1;
    tick();
    check("st_we", bus.mem_we, 1);
    check("st_adr", bus.mem_adr, 16'h0010);
    check("st_wdat", bus.mem_wdat, 16'h00AA);
    valid_ex = 1; rd1_ex = 16'hFFFF; ALUres_ex = 16'h9999; mem_write_ex = 0;
    reg_write_ex = 1; flush = 1;
    tick();
    check("st_wdat_hold", bus.mem_wdat, 16'h00AA);
    check("st_adr_hold", bus.mem_adr, 16'h0010);
    check("st_stall", stall_mem, 1);
    check("st_no_wb", valid_wb, 0);
    flush = 0;
    bus.mem_ack = 1;
    tick();
    bus.mem_ack = 0;
    clear_ex();
    check("st_valid", valid_wb, 1);
    check("st_dat", wb_dat, 16'h0010);
    check("st_rw", reg_write_wb, 0);
    tick();
    check("st_after", valid_wb, 0);

    // Timeout: load with no ack
    valid_ex = 1; ALUres_ex = 16'h0080; mem_read_ex = 1; reg_write_ex = 1;
    tick();
    clear_ex();
    req_cycles = 0;
    any_valid  = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req) req_cycles++;
      if (valid_wb) any_valid = 1;
      tick();
    end
    check("to_req_cycles", req_cycles, 4);
    check("to_no_valid", any_valid, 0);
    check("to_err", mem_err, 1);
    check("to_stall", stall_mem, 0);
    valid_ex = 1; ALUres_ex = 16'h4321; reg_write_ex = 1; wadr_ex = 1;
    tick();
    clear_ex();
    check("to_alu_valid", valid_wb, 1);
    check("to_alu_dat", wb_dat, 16'h4321);
    check("to_err_sticky", mem_err, 1);

    // Ack on the timeout cycle: ack wins
    reset = 1;
    #1 check("rst_clears_err", mem_err, 0);
    reset = 0;
    tick();
    valid_ex = 1; ALUres_ex = 16'h00C0; mem_read_ex = 1; reg_write_ex = 1;
    wadr_ex = 6;
    tick();
    clear_ex();
    tick();
    tick();
    tick();
    check("ackto_req4", bus.mem_req, 1);
    bus.mem_ack = 1; bus.mem_rdat = 16'hCAFE;
    tick();
    bus.mem_ack = 0; bus.mem_rdat = '0;
    check("ackto_valid", valid_wb, 1);
    check("ackto_dat", wb_dat, 16'hCAFE);
    check("ackto_wadr", wadr_wb, 6);
    check("ackto_err", mem_err, 0);
    check("ackto_stall", stall_mem, 0);

    // Flush in IDLE discards a load
    valid_ex = 1; ALUres_ex = 16'h0100; mem_read_ex = 1; flush = 1;
    tick();
    clear_ex();
    check("flush_req", bus.mem_req, 0);
    check("flush_stall", stall_mem, 0);
    check("flush_valid", valid_wb, 0);

    // Reset mid-access drops bus outputs without a clock edge
    valid_ex = 1; ALUres_ex = 16'h0200; mem_write_ex = 1; rd1_ex = 16'h0055;
    tick();
    clear_ex();
    check("rstacc_req_before", bus.mem_req, 1);
    #2 reset = 1;
    #1;
    check("rstacc_req", bus.mem_req, 0);
    check("rstacc_stall", stall_mem, 0);
    check("rstacc_adr", bus.mem_adr, 0);
    check("rstacc_we", bus.mem_we, 0);
    tick();
    reset = 0;
    tick();
    check("rstacc_idle", stall_mem, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 16-bit pipelined core, directly downstream of the execute stage.
- Latches the execute results (ALU result, store data, control) into an EX/MEM register.
- Performs load/store on main memory through a req/ack handshake, with a watchdog timeout.
- Presents a registered result bundle to the write-back stage and stalls upstream while a memory access is outstanding.

Parameters:
- DATA_W, 16, datapath and memory address/data width
- RADR_W, 3, register-file address width
- MEM_TIMEOUT, 255, cycles in ACCESS without mem_ack before the access is abandoned (legal range 1..2^CNT_W-1)
- CNT_W, 8, watchdog counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- valid_ex  in  1  execute stage presents an instruction
- ALUres_ex  in  DATA_W  ALU result; memory address for loads/stores
- rd1_ex  in  DATA_W  store data
- mem_read_ex  in  1  instruction is a load
- mem_write_ex  in  1  instruction is a store; mem_read_ex and mem_write_ex both 1 is illegal
- reg_write_ex  in  1  instruction writes the register file
- wadr_ex  in  RADR_W  destination register
- S_ex, Z_ex, C_ex, V_ex  in  1 each  ALU flags
- flush  in  1  discard the instruction presented this cycle
- stall_mem  out  1  upstream must hold its outputs
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_adr  out  DATA_W  memory address
- mem_wdat  out  DATA_W  memory write data
- mem_rdat  in  DATA_W  memory read data, valid when mem_ack = 1
- mem_ack  in  1  one-cycle completion pulse
- valid_wb  out  1  write-back bundle is valid (one-cycle pulse per instruction)
- wb_dat  out  DATA_W  load data or ALU result
- wadr_wb  out  RADR_W  destination register
- reg_write_wb  out  1  register write enable
- S_wb, Z_wb, C_wb, V_wb  out  1 each  flags forwarded from execute
- mem_err  out  1  sticky timeout indication

Behaviour:
- Reset (asynchronous): state = IDLE; the EX/MEM register, all wb outputs, mem_err and the watchdog clear to 0. Because mem_req, mem_we, mem_adr, mem_wdat and stall_mem are all 0 in IDLE, they drop immediately, including when reset hits mid-access.
- States: IDLE and ACCESS.
- stall_mem = (state == ACCESS). It is combinational.
- IDLE, capture enable = valid_ex & ~flush:
  - Non-memory instruction: next cycle valid_wb = 1, wb_dat = ALUres_ex, other fields copied. Latency is 1 cycle and throughput is 1 per cycle.
  - Load or store: the EX/MEM register latches address, data, control and flags. valid_wb = 0 next cycle. State moves to ACCESS and the watchdog clears.
  - If the capture enable is 0: valid_wb = 0 next cycle.
- ACCESS:
  - mem_req = 1 and mem_we = latched mem_write.
  - mem_adr and mem_wdat are driven from the EX/MEM register and held stable until ack.
  - flush is ignored and inputs are not sampled.
  - On mem_ack: next cycle valid_wb = 1, with wb_dat = mem_rdat for a load or the latched address for a store. For a store, reg_write_wb = the latched reg_write (0 from a correct decoder). State returns to IDLE, and stall_mem deasserts the cycle after the ack.
  - No ack: the watchdog increments. When it equals MEM_TIMEOUT-1 and mem_ack = 0, mem_err is set (sticky until reset), the instruction is dropped (valid_wb = 0) and state returns to IDLE.
  - If mem_ack and the timeout coincide, the ack wins and mem_err is not set.
- A memory op occupies the stage for at least 2 cycles: capture, then ack in the first ACCESS cycle. The next instruction can be captured in the cycle after the ack.
- mem_ack in IDLE is ignored.
- Flags are passed through unchanged and aligned with valid_wb.
- Widths are exact; no arithmetic is performed except the watchdog count, which never wraps because it resets on leaving ACCESS.

Decomposition:
- Package mem_pkg:
  - mem_state_t enum {IDLE, ACCESS}.
  - exmem_t struct: adr, wdat, rd, wr, reg_write, wadr, flags.
  - wb_t struct: valid, dat, wadr, reg_write, flags.
  - Default constants for DATA_W and RADR_W.
- Sub-module mem_watchdog: counter with clear/enable inputs and an expire output at MEM_TIMEOUT-1. It is parameterised by CNT_W and MEM_TIMEOUT and uses the same asynchronous reset.

Test Plan:
- ALU op: valid_ex = 1, ALUres_ex = 16'h1234, reg_write_ex = 1, wadr_ex = 3 -> next cycle valid_wb = 1, wb_dat = 16'h1234, wadr_wb = 3, stall_mem = 0 throughout.
- Load: ALUres_ex = 16'h0040, mem_read_ex = 1; mem_ack with mem_rdat = 16'hBEEF after 3 ACCESS cycles -> mem_req = 1 with mem_adr = 16'h0040, mem_we = 0 for those cycles; stall_mem high; one cycle later valid_wb = 1, wb_dat = 16'hBEEF.
- Store: ALUres_ex = 16'h0010, rd1_ex = 16'h00AA, mem_write_ex = 1; change valid_ex/rd1_ex while stalled -> mem_we = 1, mem_wdat stays 16'h00AA until ack; reg_write_wb = 0.
- Timeout: MEM_TIMEOUT = 4, load with no ack -> mem_req high exactly 4 cycles, then mem_err = 1 and valid_wb stays 0. A further ALU op still completes normally; mem_err remains 1.
- Ack on the timeout cycle -> no mem_err; load data delivered.
- Flush in IDLE with a valid load -> no mem_req and valid_wb = 0. Reset asserted during ACCESS -> mem_req and stall_mem fall to 0 immediately without waiting for a clock edge.
